// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode constants, instruction field
// positions, the bubble word and the fetch state encoding.
package mips_pkg;

    // Major opcodes that control_unit decodes from the fetch stage
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    // Instruction field bit positions (MSB / LSB)
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Word held in the IR whenever no live instruction is present
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Fetch sequencer states
    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_e;

    // Instruction addresses are always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction word and its address.
// Catches the single response that can still arrive after the consumer stalls.
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic        drain,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] data,
    output logic [31:0] pc
);
    import mips_pkg::*;

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc_q, pc_d;

    // Next-entry selection: flush beats load, load beats drain
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            pc_d    = load_pc;
        end else if (drain) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage with synchronous reset to empty
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= NOP_WORD;
            pc_q    <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign pc    = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the PC, issues 1-cycle-latency instruction memory
// reads, holds the current instruction in the IR with a skid entry behind it,
// and handles branch/jump redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
);
    import mips_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic [31:0]  ir_q, ir_d;
    logic         valid_q, valid_d;
    logic [31:0]  ir_pc_q, ir_pc_d;
    logic [31:0]  ir_pc4_q, ir_pc4_d;

    logic         req_s;
    logic         resp_s;
    logic         ir_free_s;
    logic         skid_flush_s, skid_load_s, skid_drain_s;
    logic         skid_valid_s;
    logic [31:0]  skid_data_s, skid_pc_s;

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (skid_flush_s),
        .load      (skid_load_s),
        .drain     (skid_drain_s),
        .load_data (imem_rdata),
        .load_pc   (inflight_pc_q),
        .valid     (skid_valid_s),
        .data      (skid_data_s),
        .pc        (skid_pc_s)
    );

    // Sequencer, request issue, response steering and IR update
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        ir_d          = ir_q;
        valid_d       = valid_q;
        ir_pc_d       = ir_pc_q;
        skid_flush_s  = 1'b0;
        skid_load_s   = 1'b0;
        skid_drain_s  = 1'b0;
        req_s         = 1'b0;

        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                state_d = S_RUN;
                // Never let IR + skid + in-flight exceed two words
                req_s = !redirect && !skid_valid_s && !(stall && valid_q && inflight_q);
            end
            default: state_d = S_BOOT;
        endcase

        resp_s    = inflight_q && !redirect;
        ir_free_s = !valid_q || !stall;

        if (redirect) begin
            pc_d         = word_align(redirect_pc);
            valid_d      = 1'b0;
            ir_d         = NOP_WORD;
            skid_flush_s = 1'b1;
        end else begin
            if (req_s) begin
                pc_d          = pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end else begin
                pc_d = pc_q;
            end

            if (ir_free_s) begin
                if (skid_valid_s) begin
                    // Older skid word goes first; a fresh response backfills it
                    ir_d         = skid_data_s;
                    ir_pc_d      = skid_pc_s;
                    valid_d      = 1'b1;
                    skid_drain_s = 1'b1;
                    skid_load_s  = resp_s;
                end else if (resp_s) begin
                    ir_d    = imem_rdata;
                    ir_pc_d = inflight_pc_q;
                    valid_d = 1'b1;
                end else begin
                    ir_d    = NOP_WORD;
                    valid_d = 1'b0;
                end
            end else if (resp_s) begin
                skid_load_s = 1'b1;
            end else begin
                skid_load_s = 1'b0;
            end
        end

        ir_pc4_d = ir_pc_d + 32'd4;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            ir_q          <= NOP_WORD;
            valid_q       <= 1'b0;
            ir_pc_q       <= 32'h0000_0000;
            ir_pc4_q      <= 32'h0000_0004;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            ir_q          <= ir_d;
            valid_q       <= valid_d;
            ir_pc_q       <= ir_pc_d;
            ir_pc4_q      <= ir_pc4_d;
        end
    end

    assign imem_req    = req_s;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign rs          = ir_q[RS_MSB:RS_LSB];
    assign rt          = ir_q[RT_MSB:RT_LSB];
    assign rd          = ir_q[RD_MSB:RD_LSB];
    assign shamt       = ir_q[SHAMT_MSB:SHAMT_LSB];
    assign funct       = ir_q[FUNCT_MSB:FUNCT_LSB];
    assign imm         = ir_q[IMM_MSB:IMM_LSB];
    assign pc_out      = ir_pc_q;
    assign pc_plus4    = ir_pc4_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a memory model, a program-order model of
// the delivered instruction stream and fetch pointer, and directed scenarios.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] pc_out, pc_plus4;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm         (imm),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    // Program image: a beq and an add at 0/4, unique words elsewhere
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h1022_0003;
        if (a == 32'h0000_0004) return 32'h0043_2020;
        return a ^ 32'h2400_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Synchronous memory: a request seen in one cycle returns its word the next
    logic        nxt_v = 1'b0;
    logic [31:0] nxt_w = 32'h0;
    always @(negedge clk) begin
        nxt_v = imem_req;
        nxt_w = word_at(imem_addr);
    end
    always @(posedge clk) imem_rdata <= nxt_v ? nxt_w : 32'hDEAD_BEEF;

    // Program-order model: the next instruction the IR must show and the next
    // address that must be fetched, both moved by reset, redirect and consumption
    logic [31:0] exp_pc = 32'h0, fetch_ptr = 32'h0;
    logic        seen_reset = 1'b0;
    logic        p_reset = 1'b0, p_redirect = 1'b0, p_stall = 1'b0, p_valid = 1'b0, p_req = 1'b0;
    logic [31:0] p_rpc = 32'h0;
    always @(negedge clk) begin
        logic [31:0] w;
        if (p_reset) begin
            exp_pc     = 32'h0000_0000;
            fetch_ptr  = 32'h0000_0000;
            seen_reset = 1'b1;
        end else if (p_redirect) begin
            exp_pc    = p_rpc & 32'hFFFF_FFFC;
            fetch_ptr = p_rpc & 32'hFFFF_FFFC;
        end else begin
            if (p_valid && !p_stall) exp_pc = exp_pc + 32'd4;
            if (p_req) fetch_ptr = fetch_ptr + 32'd4;
        end
        if (seen_reset) begin
            if (p_reset) begin
                chk("after_reset_valid", {31'b0, instr_valid}, 32'd0);
                chk("after_reset_req", {31'b0, imem_req}, 32'd0);
            end
            if (redirect && !reset) chk("req_during_redirect", {31'b0, imem_req}, 32'd0);
            if (imem_req) chk("fetch_addr", imem_addr, fetch_ptr);
            if (instr_valid) begin
                w = word_at(exp_pc);
                chk("pc_out", pc_out, exp_pc);
                chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
                chk("opcode", {26'b0, opcode}, (w >> 26) & 32'h3F);
                chk("rs", {27'b0, rs}, (w >> 21) & 32'h1F);
                chk("rt", {27'b0, rt}, (w >> 16) & 32'h1F);
                chk("rd", {27'b0, rd}, (w >> 11) & 32'h1F);
                chk("shamt", {27'b0, shamt}, (w >> 6) & 32'h1F);
                chk("funct", {26'b0, funct}, w & 32'h3F);
                chk("imm", {16'b0, imm}, w & 32'hFFFF);
            end else begin
                chk("nop_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
            end
        end
        p_reset    = reset;
        p_redirect = redirect;
        p_rpc      = redirect_pc;
        p_stall    = stall;
        p_valid    = instr_valid;
        p_req      = imem_req;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios with hand-computed expectations
    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Boot cycle, first request, first instruction
        @(negedge clk);
        chk("boot_req", {31'b0, imem_req}, 32'd0);
        cyc(); @(negedge clk);
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        cyc(); @(negedge clk);
        chk("second_addr", imem_addr, 32'h4);
        cyc(); @(negedge clk);
        chk("beq_valid", {31'b0, instr_valid}, 32'd1);
        chk("beq_pc", pc_out, 32'h0);
        chk("beq_pc4", pc_plus4, 32'h4);
        chk("beq_op", {26'b0, opcode}, 32'h4);
        chk("beq_rs", {27'b0, rs}, 32'd1);
        chk("beq_rt", {27'b0, rt}, 32'd2);
        chk("beq_imm", {16'b0, imm}, 32'd3);
        cyc(); @(negedge clk);
        chk("add_valid", {31'b0, instr_valid}, 32'd1);
        chk("add_op", {26'b0, opcode}, 32'h0);
        chk("add_rd", {27'b0, rd}, 32'd4);
        chk("add_funct", {26'b0, funct}, 32'h20);

        // Stall four cycles with a word in flight
        cyc(); stall = 1'b1;
        @(negedge clk);
        chk("stall_pc_start", pc_out, 32'h8);
        repeat (3) begin
            cyc(); @(negedge clk);
            chk("stall_pc_hold", pc_out, 32'h8);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_skid_full_noreq", {31'b0, imem_req}, 32'd0);
        end
        cyc(); stall = 1'b0;
        @(negedge clk);
        chk("release_pc", pc_out, 32'h8);
        cyc(); @(negedge clk);
        chk("skid_drain_pc", pc_out, 32'hC);
        chk("skid_drain_valid", {31'b0, instr_valid}, 32'd1);
        repeat (4) cyc();

        // Redirect with stall in the same cycle
        redirect = 1'b1; redirect_pc = 32'h0000_0043; stall = 1'b1;
        @(negedge clk);
        chk("redir_noreq", {31'b0, imem_req}, 32'd0);
        cyc(); redirect = 1'b0;
        @(negedge clk);
        chk("redir_valid0", {31'b0, instr_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_req", {31'b0, imem_req}, 32'd1);
        cyc(); stall = 1'b0;
        @(negedge clk);
        chk("redir_t2_valid0", {31'b0, instr_valid}, 32'd0);
        cyc(); @(negedge clk);
        chk("redir_t3_valid", {31'b0, instr_valid}, 32'd1);
        chk("redir_t3_pc", pc_out, 32'h40);
        chk("redir_t3_op", {26'b0, opcode}, 32'd9);

        // Redirect to the top of the address space and wrap
        cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc(); redirect = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cyc(); @(negedge clk);
        chk("wrap_addr1", imem_addr, 32'h0);
        chk("wrap_req1", {31'b0, imem_req}, 32'd1);
        cyc(); @(negedge clk);
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        cyc(); @(negedge clk);
        chk("wrap_next_pc", pc_out, 32'h0);

        // Reset while stalled with the skid entry occupied
        cyc(); stall = 1'b1;
        cyc(); @(negedge clk);
        chk("pre_reset_noreq", {31'b0, imem_req}, 32'd0);
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_reset_req", {31'b0, imem_req}, 32'd0);
        cyc(); @(negedge clk);
        chk("mid_reset_addr", imem_addr, 32'h0);
        chk("mid_reset_req_run", {31'b0, imem_req}, 32'd1);
        cyc(); stall = 1'b0;
        repeat (6) cyc();
        @(negedge clk);
        chk("post_reset_stream_valid", {31'b0, instr_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the single-issue MIPS core and producer side of the opcode interface consumed by control_unit.
- Owns the PC and issues requests to a synchronous instruction memory (fixed 1-cycle read latency).
- Registers each returned word into an instruction register (IR) and presents decoded fields (opcode, rs, rt, rd, shamt, funct, imm) with a valid/stall handshake.
- Accepts branch/jump redirects from the execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, IR content while instr_valid=0.

Ports:
- clk  in  1  single core clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  read request this cycle
- imem_addr  out  32  word-aligned fetch address, equals internal pc
- imem_rdata  in  32  instruction word, valid in the cycle after imem_req
- stall  in  1  downstream not accepting; hold current IR
- redirect  in  1  branch taken / jump; flush and refetch
- redirect_pc  in  32  target; bits [1:0] forced to 00
- instr_valid  out  1  IR holds a live instruction
- opcode  out  6  IR[31:26]
- rs  out  5  IR[25:21]
- rt  out  5  IR[20:16]
- rd  out  5  IR[15:11]
- shamt  out  5  IR[10:6]
- funct  out  6  IR[5:0]
- imm  out  16  IR[15:0]
- pc_out  out  32  address of instruction in IR
- pc_plus4  out  32  pc_out + 4, mod 2^32

Behaviour:
Reset: all outputs registered.
- pc=RESET_PC, IR=NOP_WORD, instr_valid=0, pc_out=0, imem_req=0.
- Skid buffer empty, inflight=0, state=S_BOOT.
- Reset asserted mid-operation discards IR, skid and any in-flight response at the next edge.

States:
- S_BOOT: one cycle, no request.
- S_BOOT -> S_RUN unconditionally.
- No other states. Redirect is handled inside S_RUN.

Request rule (S_RUN):
- imem_req = !redirect && !skid_valid && !(stall && instr_valid && inflight).
- Guarantees held + in-flight words <= 2 (IR + one skid entry).
- Each issued request sets inflight=1 for the next cycle, captures its address for pc_out, and advances pc by 4.
- pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.

Latency:
- Request in cycle n, rdata sampled in cycle n+1, instr_valid/fields visible in cycle n+2.
- With stall=0, steady state is one instruction per cycle with back-to-back requests.

Response handling (when inflight=1):
- redirect=1 this cycle: response dropped.
- else if !instr_valid || !stall: word loads IR, instr_valid=1.
- else: word loads skid buffer.

Consume:
- When instr_valid && !stall, IR is consumed at the edge.
- IR reloads from the skid if it is full, else from the response, else instr_valid=0.
- Skid always drains before a newer response; order is preserved.

Stall:
- IR, fields and pc_out are stable while stall=1 and instr_valid=1.
- stall while instr_valid=0 has no effect.

Redirect (priority over stall):
- At the edge: pc <= {redirect_pc[31:2],2'b00}, instr_valid=0, skid cleared, any response arriving that cycle discarded, no request that cycle.
- First target request is in cycle t+1; target instruction is valid in cycle t+3.

Reset has priority over redirect.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: OP_RTYPE 6'b000000, OP_REGIMM 6'b000001, OP_BEQ 6'b000100, OP_BNE 6'b000101, OP_BLEZ 6'b000110, OP_BGTZ 6'b000111
  - field bit positions
  - NOP_WORD
  - fetch state enum {S_BOOT,S_RUN}
- One sub-module: fetch_skid_buffer, a 1-entry data+pc holding register with load/drain/flush.

Test Plan:
- Reset: hold reset 3 cycles, release. Required: imem_req=0 in the S_BOOT cycle; first request addr=0x0 in cycle 2 after release; instr_valid=1 two cycles later with pc_out=0, pc_plus4=4.
- Streaming: memory returns 0x10220003 (beq) then 0x00432020 (add), stall=0. Required: opcode=000100, rs=1, rt=2, imm=3, then opcode=000000, rd=4, funct=100000 on consecutive cycles.
- Stall: stall=1 for 4 cycles while instr_valid=1. Required: IR and pc_out constant; at most one extra word enters the skid; imem_req=0 once skid full; on release the IR sequence has no gap, duplicate or reorder.
- Redirect: redirect=1, redirect_pc=0x00000043 with stall=1 in the same cycle. Required: next cycle instr_valid=0, imem_addr=0x00000040; in-flight old word never appears on the outputs.
- Wrap: redirect to 0xFFFFFFFC, stream. Required: pc_out=0xFFFFFFFC, pc_plus4=0x0, next fetch addr=0x0.
- Reset mid-stall with a full skid. Required: next cycle instr_valid=0, pc=RESET_PC; stale words never issued.
